// File: rtl/cones_pkg.sv
// cones_pkg: shared defaults and count-width helper for the cones pipeline
package cones_pkg;
   localparam int DEF_WIDTH = 1;
   localparam int DEF_DEPTH = 2;
   function automatic int count_w(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/cones_stage.sv
// cones_stage: one valid/data register of the pipeline, optionally storing the inverse of its input
module cones_stage #(
   parameter int   WIDTH  = 1,
   parameter logic INVERT = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             ready_i,
   input  logic             valid_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
);
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;
   // a ready stage takes whatever is offered (possibly a bubble); flush empties it but leaves data alone
   always_comb begin
      valid_d = flush_i ? 1'b0 : (ready_i ? valid_i : valid_q);
      data_d  = (!flush_i && ready_i && valid_i) ? (INVERT ? ~data_i : data_i) : data_q;
   end
   // stage register, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end
   assign valid_o = valid_q;
   assign data_o  = data_q;
endmodule

// File: rtl/cones_pipe.sv
// cones_pipe: elastic register pipeline with per-stage inversion, flush and occupancy count
module cones_pipe import cones_pkg::*; #(
   parameter int               WIDTH       = DEF_WIDTH,
   parameter int               DEPTH       = DEF_DEPTH,
   parameter logic [DEPTH-1:0] INVERT_MASK = '1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   input  logic [WIDTH-1:0]          in_data,
   output logic                      in_ready,
   output logic                      out_valid,
   output logic [WIDTH-1:0]          out_data,
   input  logic                      out_ready,
   input  logic                      flush,
   output logic [count_w(DEPTH)-1:0] count
);
   localparam int CW = count_w(DEPTH);
   logic [DEPTH-1:0] ready, valid, vin;
   logic [WIDTH-1:0] data [DEPTH];
   logic [WIDTH-1:0] din  [DEPTH];
   logic [CW-1:0]    count_q, count_d;
   logic             acc, emit;
   genvar g;
   generate
      for (g = 0; g < DEPTH; g++) begin : g_st
         // a stage can take an item when out_ready or any stage from here to the end is empty
         assign ready[g] = out_ready || !(&valid[DEPTH-1:g]);
         if (g == 0) begin : g_head
            assign vin[g] = in_valid;
            assign din[g] = in_data;
         end else begin : g_body
            assign vin[g] = valid[g-1];
            assign din[g] = data[g-1];
         end
         cones_stage #(.WIDTH(WIDTH), .INVERT(INVERT_MASK[g])) u_stage (
            .clk(clk), .rst_n(rst_n), .flush_i(flush), .ready_i(ready[g]),
            .valid_i(vin[g]), .data_i(din[g]), .valid_o(valid[g]), .data_o(data[g])
         );
      end
   endgenerate
   assign in_ready  = ready[0] && !flush;
   assign out_valid = valid[DEPTH-1];
   assign out_data  = data[DEPTH-1];
   assign acc       = in_valid && in_ready;
   assign emit      = out_valid && out_ready;
   // occupancy tracks accepts minus emits; flush empties the pipe
   always_comb count_d = flush ? '0 : count_q + CW'(acc) - CW'(emit);
   // occupancy register, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
   end
   assign count = count_q;
endmodule

// File: tb/tb_cones_pipe.sv
// tb_cones_pipe: randomized and directed checks of cones_pipe against a queue-based model
module tb_cones_pipe;
   localparam int D = 2;
   localparam logic [1:0] MASK_A = 2'b11;
   localparam logic [1:0] MASK_B = 2'b01;
   typedef struct {logic [1:0] d; int p;} item_t;
   logic clk = 1'b0, rst_n = 1'b0;
   logic in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
   logic [1:0] in_data = '0;
   logic in_ready_a, out_valid_a, in_ready_b, out_valid_b;
   logic [1:0] out_data_a, out_data_b, count_a, count_b;
   item_t q[$];
   int nchecks = 0, nerr = 0;

   cones_pipe #(.WIDTH(2), .DEPTH(D), .INVERT_MASK(MASK_A)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_a),
      .out_valid(out_valid_a), .out_data(out_data_a), .out_ready(out_ready), .flush(flush), .count(count_a));
   cones_pipe #(.WIDTH(2), .DEPTH(D), .INVERT_MASK(MASK_B)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
      .out_valid(out_valid_b), .out_data(out_data_b), .out_ready(out_ready), .flush(flush), .count(count_b));

   always #5 clk = ~clk;

   function automatic logic [1:0] xf(input logic [1:0] d, input logic [1:0] m);
      return ($countones(m) % 2 == 1) ? ~d : d;
   endfunction

   task automatic chk(input string n, input int act, input int exp);
      nchecks++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
      end
   endtask

   // the model's view of the outputs for the inputs currently applied
   task automatic compare();
      logic er, ev;
      er = !flush && (q.size() < D || out_ready);
      ev = q.size() > 0 && q[0].p == D - 1;
      chk("in_ready_a", in_ready_a, er);
      chk("in_ready_b", in_ready_b, er);
      chk("out_valid_a", out_valid_a, ev);
      chk("out_valid_b", out_valid_b, ev);
      chk("count_a", count_a, q.size());
      chk("count_b", count_b, q.size());
      if (ev) begin
         chk("out_data_a", out_data_a, xf(q[0].d, MASK_A));
         chk("out_data_b", out_data_b, xf(q[0].d, MASK_B));
      end
   endtask

   // items advance as far as the pipe allows; the oldest leaves from the last position
   task automatic model_update(input logic v, input logic [1:0] d, input logic ordy, input logic fl);
      logic acc;
      int lim;
      acc = v && !fl && (q.size() < D || ordy);
      if (q.size() > 0 && q[0].p == D - 1 && ordy) void'(q.pop_front());
      if (fl) q.delete();
      else begin
         for (int k = 0; k < q.size(); k++) begin
            lim = (k == 0) ? D - 1 : q[k-1].p - 1;
            q[k].p = (q[k].p + 1 < lim) ? q[k].p + 1 : lim;
         end
         if (acc) q.push_back('{d: d, p: 0});
      end
   endtask

   task automatic step(input logic v, input logic [1:0] d, input logic ordy, input logic fl);
      @(negedge clk);
      in_valid = v; in_data = d; out_ready = ordy; flush = fl;
      #1 compare();
      @(posedge clk);
      if (rst_n) model_update(v, d, ordy, fl);
      #1 in_valid = 1'b0; flush = 1'b0;
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid_a, 0);
      chk("rst_count", count_a, 0);
      chk("rst_out_data_b", out_data_b, 0);
      chk("rst_in_ready", in_ready_a, 1);
      @(negedge clk) rst_n = 1'b1;
      // single item through both masks
      step(1, 2'b01, 1, 0);
      step(0, 2'b00, 1, 0);
      chk("lat_out_valid", out_valid_a, 1);
      chk("mask11_data", out_data_a, 2'b01);
      chk("mask01_data", out_data_b, 2'b10);
      step(0, 2'b00, 1, 0);
      chk("drain_count", count_a, 0);
      // fill while stalled, then drain in order
      step(1, 2'b00, 0, 0);
      step(1, 2'b11, 0, 0);
      chk("full_count", count_a, 2);
      chk("full_in_ready", in_ready_a, 0);
      chk("full_head_data", out_data_a, 2'b00);
      step(0, 2'b00, 1, 0);
      chk("drain1_count", count_a, 1);
      chk("drain1_data", out_data_a, 2'b11);
      step(0, 2'b00, 1, 0);
      chk("drain2_count", count_a, 0);
      // flush a full pipe
      step(1, 2'b10, 0, 0);
      step(1, 2'b01, 0, 0);
      step(0, 2'b00, 0, 1);
      chk("flush_count", count_a, 0);
      chk("flush_out_valid", out_valid_a, 0);
      chk("flush_in_ready", in_ready_a, 1);
      // back-to-back stream
      for (int i = 0; i < 10; i++) begin
         step(i < 8, 2'(i), 1, 0);
         if (i >= 1 && i <= 8) chk("stream_out_valid", out_valid_a, 1);
         if (i >= 1 && i <= 7) chk("stream_count", count_a, 2);
      end
      // asynchronous reset with a full pipe
      step(1, 2'b11, 0, 0);
      step(1, 2'b10, 0, 0);
      chk("pre_areset_count", count_a, 2);
      #1 rst_n = 1'b0;
      #1;
      chk("areset_out_valid", out_valid_a, 0);
      chk("areset_count", count_a, 0);
      chk("areset_count_b", count_b, 0);
      q.delete();
      @(negedge clk) rst_n = 1'b1;
      step(1, 2'b10, 1, 0);
      step(0, 2'b00, 1, 0);
      chk("post_reset_data_b", out_data_b, 2'b01);
      // randomized traffic
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 3) != 0, 2'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end
endmodule

// File: doc/cones_pipe.md
CONES_PIPE -- requirements
Module: cones_pipe

Interface
REQ-001 Parameter WIDTH, default 1, data bit width per item (>=1).
REQ-002 Parameter DEPTH, default 2, number of register stages (>=1).
REQ-003 Parameter INVERT_MASK, default all ones (DEPTH bits), bit i set means stage i stores the bitwise inverse of its input.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 in_valid  input  1  upstream item present.
REQ-007 in_data  input  WIDTH  upstream item.
REQ-008 in_ready  output  1  stage 0 accepts this cycle.
REQ-009 out_valid  output  1  last stage holds an item.
REQ-010 out_data  output  WIDTH  last-stage data register.
REQ-011 out_ready  input  1  downstream accepts.
REQ-012 flush  input  1  synchronous discard of all held items.
REQ-013 count  output  $clog2(DEPTH+1)  items currently held, 0..DEPTH.

Function
REQ-014 Each stage i SHALL hold valid_i and data_i; stage i input is in_data for i=0, else data_{i-1}.
REQ-015 Stage i ready SHALL be !valid_i || ready_{i+1}; ready_DEPTH = out_ready; in_ready = ready_0 && !flush.
REQ-016 On transfer into stage i, data_i SHALL load INVERT_MASK[i] ? ~input : input and valid_i SHALL set; if stage i drains without refill, valid_i SHALL clear.
REQ-017 A stage that is not ready SHALL hold data_i and valid_i unchanged.
REQ-018 Unstalled latency SHALL be exactly DEPTH cycles from in_valid&&in_ready to out_valid; throughput one item per cycle.
REQ-019 Items SHALL leave in arrival order; none dropped or duplicated while flush=0.
REQ-020 out_data SHALL equal data_{DEPTH-1}; out_valid SHALL equal valid_{DEPTH-1}.
REQ-021 count SHALL equal the number of set valid_i bits, updated registered each cycle (+1 accept, -1 emit, net 0 on both).
REQ-022 Full (count=DEPTH, out_ready=0): in_ready SHALL be 0; with out_ready=1 the same cycle, accept and emit both occur, count stays DEPTH.
REQ-023 flush=1: all valid_i and count SHALL be 0 next cycle; no accept that cycle; an emit with out_ready=1 still counts as delivered; data registers unchanged.
REQ-024 in_valid=0 with ready stage 0: bubble propagates; data_0 holds.

Reset
REQ-025 rst_n low SHALL asynchronously clear all valid_i, data_i and count to 0; out_valid=0, out_data=0, count=0, in_ready=1 while flush=0.
REQ-026 Reset mid-operation SHALL discard all items; first accepted item after release emerges DEPTH cycles later.

Structure
REQ-027 Package cones_pkg SHALL hold default WIDTH, DEPTH and a function computing count width.
REQ-028 One sub-module cones_stage (single valid/data register with invert flag) SHALL be instantiated DEPTH times via generate.
REQ-029 Implementation SHALL contain no combinational path from in_valid to out_valid; ready chain is combinational.

Verification
REQ-030 WIDTH=2, DEPTH=2, mask=2'b11, out_ready=1: in_data=2'b01 at cycle 0 -> out_valid=1, out_data=2'b01 at cycle 2.
REQ-031 Same, mask=2'b01: in_data=2'b01 -> out_data=2'b10 after 2 cycles.
REQ-032 out_ready=0, push 2'b00 then 2'b11 -> count=2, in_ready=0; raise out_ready -> 2'b00 then 2'b11 emitted on consecutive cycles, count 1 then 0.
REQ-033 count=2, assert flush one cycle -> next cycle count=0, out_valid=0, in_ready=1.
REQ-034 Stream 8 back-to-back items, out_ready=1 -> 8 outputs on 8 consecutive cycles, order preserved, count steady at 2.
REQ-035 Assert rst_n low asynchronously with count=2 -> out_valid=0, count=0 immediately, without a clock edge.
